// File: rtl/sprite_motion_sched_pkg.sv
// Shared types for the sprite motion scheduler.
// Sprite state record, FSM states and colour stepping.
package sprite_pkg;

    localparam int WIDTH_DEF  = 800;
    localparam int HEIGHT_DEF = 600;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        dir_x;
        logic        dir_y;
        logic [2:0]  color;
        logic        en;
    } sprite_t;

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    // Colour cycles 1..7; black is never re-entered.
    function automatic logic [2:0] color_next(input logic [2:0] c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

endpackage

// File: rtl/sprite_motion_sched_if.sv
// MCU-side sprite configuration port.
// The MCU is the master; the scheduler answers with cfg_ready.
interface sprite_motion_sched_if #(
    parameter int IW = 2
);
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [10:0]   cfg_x;
    logic [10:0]   cfg_y;
    logic [1:0]    cfg_dir;
    logic [2:0]    cfg_color;
    logic          cfg_en;
    logic          cfg_ready;

    modport master (
        output cfg_we, cfg_idx, cfg_x, cfg_y,
        output cfg_dir, cfg_color, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_x, cfg_y,
        input  cfg_dir, cfg_color, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/sprite_motion_sched_step.sv
// Combinational bounce/step of one sprite.
// Shared by all sprites through the scheduler.
module sprite_step
    import sprite_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  sprite_t cur,
    output sprite_t nxt
);
    localparam logic [10:0] XMAX = 11'(WIDTH - 1);
    localparam logic [10:0] YMAX = 11'(HEIGHT - 1);

    logic bx;
    logic by;
    logic dx;
    logic dy;

    // Edge hit flips direction before stepping; one colour bump per pass.
    always_comb begin
        nxt = cur;
        bx  = (cur.x == 11'd0) || (cur.x == XMAX);
        by  = (cur.y == 11'd0) || (cur.y == YMAX);
        dx  = cur.dir_x ^ bx;
        dy  = cur.dir_y ^ by;
        nxt.dir_x = dx;
        nxt.dir_y = dy;
        nxt.x = dx ? cur.x + 11'd1 : cur.x - 11'd1;
        nxt.y = dy ? cur.y + 11'd1 : cur.y - 11'd1;
        if (bx || by) begin
            nxt.color = color_next(cur.color);
        end
    end
endmodule

// File: rtl/sprite_motion_sched.sv
// Frame-synchronous sprite motion scheduler and pixel arbiter.
// One shared step unit walks all sprites during vertical blanking.
module sprite_motion_sched
    import sprite_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int HEIGHT    = HEIGHT_DEF,
    parameter int NUM_SPR   = 4,
    parameter int HALF      = 2,
    parameter int FRAME_DIV = 2
) (
    input  logic                 pixel_clk,
    input  logic                 rst,
    input  logic [10:0]          hcnt,
    input  logic [10:0]          vcnt,
    sprite_motion_sched_if.slave cfg,
    output logic                 busy,
    output logic                 frame_tick,
    output logic [2:0]           pixel_r_out,
    output logic [2:0]           pixel_g_out,
    output logic [2:0]           pixel_b_out
);
    localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_SPR - 1);
    localparam logic [DW-1:0] DMAX = DW'(FRAME_DIV - 1);
    localparam logic [10:0]   XMAX = 11'(WIDTH - 1);
    localparam logic [10:0]   YMAX = 11'(HEIGHT - 1);
    localparam logic [11:0]   H12  = 12'(HALF);

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_n;
    logic          start;
    logic          pending;
    logic [DW-1:0] div;
    sprite_t       spr [NUM_SPR];
    sprite_t       cur;
    sprite_t       stepped;
    sprite_t       wr;
    logic          wr_ok;
    logic          hit;
    logic [2:0]    col;
    logic          active;

    assign busy          = (state == UPDATE);
    assign cfg.cfg_ready = rst && (state == IDLE);
    assign wr_ok         = cfg.cfg_we && cfg.cfg_ready;

    // Sprite currently owned by the shared step unit.
    always_comb begin
        cur = spr[idx];
    end

    sprite_step #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_step (
        .cur (cur),
        .nxt (stepped)
    );

    // Incoming config record, clamped into the visible area.
    always_comb begin
        wr.x     = (cfg.cfg_x > XMAX) ? XMAX : cfg.cfg_x;
        wr.y     = (cfg.cfg_y > YMAX) ? YMAX : cfg.cfg_y;
        wr.dir_x = cfg.cfg_dir[0];
        wr.dir_y = cfg.cfg_dir[1];
        wr.color = cfg.cfg_color;
        wr.en    = cfg.cfg_en;
    end

    // Pass sequencing: IDLE waits for a pending tick, UPDATE walks idx.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    state_n = UPDATE;
                    idx_n   = '0;
                    start   = 1'b1;
                end
            end
            UPDATE: begin
                if (idx == LAST) begin
                    state_n = IDLE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and sprite index registers.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Frame tick, frame divider and pending-pass flag; a new set wins.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
            div        <= '0;
            pending    <= 1'b0;
        end else begin
            frame_tick <= (hcnt == 11'd0) && (vcnt == 11'(HEIGHT));
            if (start) begin
                pending <= 1'b0;
            end
            if (frame_tick) begin
                if (div == DMAX) begin
                    div     <= '0;
                    pending <= 1'b1;
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

    // Sprite table: config writes in IDLE, steps of enabled sprites in UPDATE.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                spr[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                spr[cfg.cfg_idx] <= wr;
            end
            if (busy && cur.en) begin
                spr[idx] <= stepped;
            end
        end
    end

    // Coverage search; descending scan leaves the lowest index winning.
    always_comb begin
        hit    = 1'b0;
        col    = 3'd0;
        active = (hcnt < 11'(WIDTH)) && (vcnt < 11'(HEIGHT));
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (spr[i].en &&
                ({1'b0, hcnt} + H12 >= {1'b0, spr[i].x}) &&
                ({1'b0, hcnt} <= {1'b0, spr[i].x} + H12) &&
                ({1'b0, vcnt} + H12 >= {1'b0, spr[i].y}) &&
                ({1'b0, vcnt} <= {1'b0, spr[i].y} + H12)) begin
                hit = 1'b1;
                col = spr[i].color;
            end
        end
    end

    // Registered pixel drive, full intensity per set colour bit.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            pixel_r_out <= 3'd0;
            pixel_g_out <= 3'd0;
            pixel_b_out <= 3'd0;
        end else begin
            pixel_r_out <= (active && hit && col[2]) ? 3'b111 : 3'b000;
            pixel_g_out <= (active && hit && col[1]) ? 3'b111 : 3'b000;
            pixel_b_out <= (active && hit && col[0]) ? 3'b111 : 3'b000;
        end
    end
endmodule

// File: tb/tb_sprite_motion_sched.sv
// Scoreboard bench for sprite_motion_sched.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_sprite_motion_sched;
    import sprite_pkg::*;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcnt = 11'd1;
    logic [10:0] vcnt = 11'd700;
    logic        busy;
    logic        frame_tick;
    logic [2:0]  pixel_r_out;
    logic [2:0]  pixel_g_out;
    logic [2:0]  pixel_b_out;

    logic        probe = 1'b0;
    logic        probe_d = 1'b0;
    logic [8:0]  pq[$];
    string       pn[$];
    dchk_t       dq[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    int          b0;

    sprite_motion_sched_if #(.IW(2)) cfg_if ();

    sprite_motion_sched dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .cfg         (cfg_if),
        .busy        (busy),
        .frame_tick  (frame_tick),
        .pixel_r_out (pixel_r_out),
        .pixel_g_out (pixel_g_out),
        .pixel_b_out (pixel_b_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        forever begin
            @(posedge pixel_clk);
            probe_d = probe;
        end
    end

    // Monitor: busy cycle count, pixel scoreboard, queued direct checks.
    initial begin
        dchk_t d;
        logic [8:0] e;
        string n;
        logic [8:0] a;
        forever begin
            @(negedge pixel_clk);
            if (busy) busy_cnt++;
            if (probe_d) begin
                a = {pixel_r_out, pixel_g_out, pixel_b_out};
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pixel: output with no expectation, got %h", a);
                end else begin
                    e = pq.pop_front();
                    n = pn.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", n, a, e);
                    end
                end
            end
            while (dq.size() > 0) begin
                d = dq.pop_front();
                checks++;
                if (d.act !== d.exp) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d", d.nm, d.act, d.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] rgb(input logic [2:0] c);
        return {c[2] ? 3'b111 : 3'b000,
                c[1] ? 3'b111 : 3'b000,
                c[0] ? 3'b111 : 3'b000};
    endfunction

    task automatic dchk(input string nm, input logic [31:0] a, input logic [31:0] e);
        dq.push_back('{nm, a, e});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pixel_clk); #1;
            probe = 1'b0;
            hcnt = 11'd1;
            vcnt = 11'd700;
        end
    endtask

    task automatic pix(input string nm, input int h, input int v, input logic [8:0] e);
        @(posedge pixel_clk); #1;
        hcnt = 11'(h);
        vcnt = 11'(v);
        pq.push_back(e);
        pn.push_back(nm);
        probe = 1'b1;
    endtask

    // Pins a sprite centre: probes +-2 (covered) and +-3 (uncovered) on both axes.
    task automatic probe_pos(input string nm, input int cx, input int cy, input logic [2:0] c);
        int offs [5] = '{-3, -2, 0, 2, 3};
        int h;
        int v;
        logic [8:0] e;
        for (int k = 0; k < 5; k++) begin
            h = cx + offs[k];
            e = (offs[k] >= -2 && offs[k] <= 2 && h < 800 && cy < 600) ? rgb(c) : 9'd0;
            if (h >= 0) pix($sformatf("%s h%0d", nm, h), h, cy, e);
        end
        for (int k = 0; k < 5; k++) begin
            v = cy + offs[k];
            e = (offs[k] >= -2 && offs[k] <= 2 && cx < 800 && v < 600) ? rgb(c) : 9'd0;
            if (v >= 0 && k != 2) pix($sformatf("%s v%0d", nm, v), cx, v, e);
        end
        idle(2);
    endtask

    task automatic cfg_write(input logic [1:0] i, input int x, input int y,
                             input logic [1:0] dir, input logic [2:0] c, input logic en);
        @(posedge pixel_clk); #1;
        probe = 1'b0;
        cfg_if.cfg_idx   = i;
        cfg_if.cfg_x     = 11'(x);
        cfg_if.cfg_y     = 11'(y);
        cfg_if.cfg_dir   = dir;
        cfg_if.cfg_color = c;
        cfg_if.cfg_en    = en;
        cfg_if.cfg_we    = 1'b1;
        @(posedge pixel_clk); #1;
        cfg_if.cfg_we    = 1'b0;
    endtask

    task automatic tick();
        @(posedge pixel_clk); #1;
        probe = 1'b0;
        hcnt = 11'd0;
        vcnt = 11'd600;
        @(posedge pixel_clk); #1;
        hcnt = 11'd1;
        @(negedge pixel_clk);
        dchk("frame_tick pulse", 32'(frame_tick), 32'd1);
        @(posedge pixel_clk); #1;
        vcnt = 11'd700;
        @(negedge pixel_clk);
        dchk("frame_tick one cycle", 32'(frame_tick), 32'd0);
    endtask

    task automatic do_pass();
        b0 = busy_cnt;
        tick();
        idle(8);
        dchk("no pass after one tick", 32'(busy_cnt - b0), 32'd0);
        tick();
        idle(12);
        dchk("pass length", 32'(busy_cnt - b0), 32'd4);
    endtask

    task automatic wait_busy(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge pixel_clk);
            if (busy) seen = 1'b1;
        end
        dchk(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_idx   = '0;
        cfg_if.cfg_x     = '0;
        cfg_if.cfg_y     = '0;
        cfg_if.cfg_dir   = '0;
        cfg_if.cfg_color = '0;
        cfg_if.cfg_en    = 1'b0;

        // Reset state
        repeat (3) @(negedge pixel_clk);
        dchk("reset busy", 32'(busy), 32'd0);
        dchk("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
        dchk("reset pixel", 32'({pixel_r_out, pixel_g_out, pixel_b_out}), 32'd0);
        dchk("reset frame_tick", 32'(frame_tick), 32'd0);
        rst = 1'b1;
        #1;
        dchk("cfg_ready after release", 32'(cfg_if.cfg_ready), 32'd1);
        pix("reset sprite disabled", 0, 0, 9'd0);
        idle(2);

        // Basic step: (100,50) dir 11 colour 3 -> (101,51) colour 3
        cfg_write(2'd0, 100, 50, 2'b11, 3'd3, 1'b1);
        pix("s0 loaded", 100, 50, rgb(3'd3));
        idle(1);
        do_pass();
        probe_pos("step", 101, 51, 3'd3);

        // Right edge bounce with colour wrap 7 -> 1
        cfg_write(2'd0, 799, 300, 2'b11, 3'd7, 1'b1);
        do_pass();
        probe_pos("right edge", 798, 301, 3'd1);

        // Corner: single colour increment, both directions flip
        cfg_write(2'd0, 0, 0, 2'b00, 3'd2, 1'b1);
        do_pass();
        probe_pos("corner", 1, 1, 3'd3);
        do_pass();
        probe_pos("after corner", 2, 2, 3'd3);

        // Priority: lowest index wins, out-of-box and off-screen are black
        cfg_write(2'd0, 200, 200, 2'b00, 3'd4, 1'b1);
        cfg_write(2'd1, 200, 200, 2'b00, 3'd1, 1'b1);
        pix("priority centre", 200, 200, 9'b111_000_000);
        pix("priority corner", 202, 202, 9'b111_000_000);
        pix("outside box", 203, 200, 9'd0);
        pix("off screen", 850, 200, 9'd0);
        idle(1);
        cfg_write(2'd0, 200, 200, 2'b00, 3'd4, 1'b0);
        pix("s1 shows when s0 off", 200, 200, 9'b000_000_111);
        idle(1);

        // Write during busy is ignored
        b0 = busy_cnt;
        tick();
        tick();
        wait_busy("busy seen for ignored write");
        cfg_if.cfg_idx   = 2'd0;
        cfg_if.cfg_x     = 11'd10;
        cfg_if.cfg_y     = 11'd10;
        cfg_if.cfg_dir   = 2'b00;
        cfg_if.cfg_color = 3'd7;
        cfg_if.cfg_en    = 1'b1;
        cfg_if.cfg_we    = 1'b1;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        cfg_if.cfg_we    = 1'b0;
        idle(10);
        dchk("busy pass length", 32'(busy_cnt - b0), 32'd4);
        pix("busy write ignored", 10, 10, 9'd0);
        pix("s1 moved", 199, 199, 9'b000_000_111);
        pix("s1 moved edge", 202, 199, 9'd0);
        idle(1);

        // Clamp x in IDLE: 900 -> 799
        cfg_write(2'd0, 900, 10, 2'b00, 3'd7, 1'b1);
        pix("clamp centre", 799, 10, 9'h1ff);
        pix("clamp left", 797, 10, 9'h1ff);
        pix("clamp outside", 796, 10, 9'd0);
        idle(1);

        // Reset in the middle of a pass (idx 2)
        tick();
        tick();
        wait_busy("busy seen before mid reset");
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        rst = 1'b0;
        #1;
        dchk("mid reset busy", 32'(busy), 32'd0);
        dchk("mid reset pixel", 32'({pixel_r_out, pixel_g_out, pixel_b_out}), 32'd0);
        dchk("mid reset frame_tick", 32'(frame_tick), 32'd0);
        dchk("mid reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
        repeat (2) @(negedge pixel_clk);
        rst = 1'b1;
        #1;
        dchk("cfg_ready after mid reset", 32'(cfg_if.cfg_ready), 32'd1);
        pix("s0 cleared", 799, 10, 9'd0);
        pix("s1 cleared", 199, 199, 9'd0);
        idle(1);
        do_pass();

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
